// File: rtl/lfsr_galois_multi.sv
// Parametrised LFSR (Galois or Fibonacci form) with N steps per enabled cycle,
// parallel load, zero-load lock-up recovery and a seed-to-seed period monitor.
module lfsr_galois_multi #(
    parameter int unsigned      WIDTH     = 5,
    parameter logic [WIDTH-1:0] TAPS      = 5'b10100,
    parameter bit               FIBONACCI = 1'b0,
    parameter int unsigned      STEPS     = 1,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             seed_hit,
    output logic             lockup,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH-1:0] period_n;
    logic             hit_n;
    logic             lock_n;
    logic             pv_n;

    // One shift of the register in the configured form.
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        n = s >> 1;
        if (FIBONACCI) begin
            n[WIDTH-1] = ^(s & TAPS);
        end else begin
            n[WIDTH-1] = s[0];
            for (int unsigned i = 0; i < WIDTH - 1; i++) begin
                n[i] = s[i+1] ^ (TAPS[i] & s[0]);
            end
        end
        return n;
    endfunction

    // STEPS shifts chained combinationally; only the final state is used.
    always_comb begin : step_unroll
        stepped = q;
        for (int unsigned k = 0; k < STEPS; k++) begin
            stepped = step1(stepped);
        end
    end

    assign cnt_inc = (cnt == ALL_ONES) ? cnt : cnt + WIDTH'(1);

    // Next-state selection: load beats en; idle holds everything but the pulse.
    always_comb begin : next_state
        q_n      = q;
        cnt_n    = cnt;
        period_n = period;
        pv_n     = period_valid;
        lock_n   = lockup;
        hit_n    = 1'b0;
        if (load) begin
            cnt_n = '0;
            if (load_value == '0) begin
                q_n    = SEED;
                lock_n = 1'b1;
            end else begin
                q_n = load_value;
            end
        end else if (en) begin
            q_n = stepped;
            if (stepped == SEED) begin
                hit_n    = 1'b1;
                period_n = cnt_inc;
                pv_n     = 1'b1;
                cnt_n    = '0;
            end else begin
                cnt_n = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            q            <= SEED;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            lockup       <= 1'b0;
            seed_hit     <= 1'b0;
        end else begin
            q            <= q_n;
            cnt          <= cnt_n;
            period       <= period_n;
            period_valid <= pv_n;
            lockup       <= lock_n;
            seed_hit     <= hit_n;
        end
    end

endmodule

// File: tb/tb_lfsr_galois_multi.sv
// Bench for lfsr_galois_multi: directed vector table, hand-written corner sequences,
// and randomized traffic against an arithmetic reference model on four instances.
module tb_lfsr_galois_multi;

    localparam int unsigned WA = 5;
    localparam int unsigned WC = 8;

    typedef struct {
        int unsigned w;
        int unsigned taps;
        int unsigned steps;
        int unsigned seed;
        bit          fib;
    } cfg_t;

    typedef struct {
        int unsigned q;
        int unsigned cnt;
        int unsigned period;
        bit          hit;
        bit          lock;
        bit          pv;
    } model_t;

    typedef struct {
        bit         rst;
        bit         ld;
        bit         en;
        logic [4:0] lv;
        logic [4:0] q;
        bit         hit;
        bit         lock;
        logic [4:0] per;
        bit         pv;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          ra, la, ea;
    logic [WA-1:0] lva;
    logic [WA-1:0] qa, pera, qb, perb;
    logic          hita, locka, pva, hitb, lockb, pvb;

    logic          rc, lc, ec;
    logic [WC-1:0] lvc;
    logic [WC-1:0] qc, perc, qd, perd;
    logic          hitc, lockc, pvc, hitd, lockd, pvd;

    int total = 0;
    int bad   = 0;

    cfg_t   cfg_a, cfg_b, cfg_c, cfg_d;
    model_t ma, mb, mc, md;
    vec_t   tbl [15];

    lfsr_galois_multi dut_a (
        .clk(clk), .reset(ra), .en(ea), .load(la), .load_value(lva),
        .q(qa), .seed_hit(hita), .lockup(locka), .period(pera), .period_valid(pva)
    );

    lfsr_galois_multi #(.STEPS(2)) dut_b (
        .clk(clk), .reset(ra), .en(ea), .load(la), .load_value(lva),
        .q(qb), .seed_hit(hitb), .lockup(lockb), .period(perb), .period_valid(pvb)
    );

    // 8'h87 gives the maximal-length recurrence x^8 = x^7 + x^2 + x + 1 in Fibonacci form.
    lfsr_galois_multi #(.WIDTH(8), .TAPS(8'h87), .FIBONACCI(1'b1), .STEPS(1), .SEED(8'h01)) dut_c (
        .clk(clk), .reset(rc), .en(ec), .load(lc), .load_value(lvc),
        .q(qc), .seed_hit(hitc), .lockup(lockc), .period(perc), .period_valid(pvc)
    );

    lfsr_galois_multi #(.WIDTH(8), .TAPS(8'h87), .FIBONACCI(1'b1), .STEPS(3), .SEED(8'h01)) dut_d (
        .clk(clk), .reset(rc), .en(ec), .load(lc), .load_value(lvc),
        .q(qd), .seed_hit(hitd), .lockup(lockd), .period(perd), .period_valid(pvd)
    );

    function automatic int unsigned ref_step(input int unsigned s, input cfg_t c);
        int unsigned msb;
        msb = 32'd1 << (c.w - 1);
        if (c.fib)
            return (s >> 1) | ((($countones(s & c.taps) % 2) == 1) ? msb : 32'd0);
        return ((s & 32'd1) != 0) ? ((s >> 1) ^ c.taps) : (s >> 1);
    endfunction

    function automatic model_t model_next(input model_t m, input cfg_t c,
                                          input bit rst, input bit ld, input bit en,
                                          input int unsigned lv);
        model_t      n;
        int unsigned mx;
        n     = m;
        mx    = (32'd1 << c.w) - 1;
        n.hit = 1'b0;
        if (rst) begin
            n.q = c.seed; n.cnt = 0; n.period = 0; n.pv = 1'b0; n.lock = 1'b0;
        end else if (ld) begin
            n.cnt = 0;
            if (lv == 0) begin
                n.q = c.seed; n.lock = 1'b1;
            end else begin
                n.q = lv;
            end
        end else if (en) begin
            for (int s = 0; s < int'(c.steps); s++) n.q = ref_step(n.q, c);
            if (n.q == c.seed) begin
                n.hit    = 1'b1;
                n.period = (m.cnt >= mx) ? mx : m.cnt + 1;
                n.pv     = 1'b1;
                n.cnt    = 0;
            end else begin
                n.cnt = (m.cnt >= mx) ? mx : m.cnt + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag, input model_t m, input logic [31:0] q,
                             input logic hit, input logic lock,
                             input logic [31:0] per, input logic pv);
        chk({tag, ".q"}, q, m.q);
        chk({tag, ".seed_hit"}, 32'(hit), 32'(m.hit));
        chk({tag, ".lockup"}, 32'(lock), 32'(m.lock));
        chk({tag, ".period"}, per, m.period);
        chk({tag, ".period_valid"}, 32'(pv), 32'(m.pv));
    endtask

    // Advance one clock, sample after the edge, and step every reference model.
    task automatic tick();
        @(posedge clk);
        #1;
        ma = model_next(ma, cfg_a, ra, la, ea, 32'(lva));
        mb = model_next(mb, cfg_b, ra, la, ea, 32'(lva));
        mc = model_next(mc, cfg_c, rc, lc, ec, 32'(lvc));
        md = model_next(md, cfg_d, rc, lc, ec, 32'(lvc));
    endtask

    task automatic chk_group_a();
        chk_model("a", ma, 32'(qa), hita, locka, 32'(pera), pva);
        chk_model("b", mb, 32'(qb), hitb, lockb, 32'(perb), pvb);
    endtask

    task automatic chk_group_c();
        chk_model("c", mc, 32'(qc), hitc, lockc, 32'(perc), pvc);
        chk_model("d", md, 32'(qd), hitd, lockd, 32'(perd), pvd);
    endtask

    initial begin
        cfg_a = '{w: 5, taps: 32'h14, steps: 1, seed: 1, fib: 1'b0};
        cfg_b = '{w: 5, taps: 32'h14, steps: 2, seed: 1, fib: 1'b0};
        cfg_c = '{w: 8, taps: 32'h87, steps: 1, seed: 1, fib: 1'b1};
        cfg_d = '{w: 8, taps: 32'h87, steps: 3, seed: 1, fib: 1'b1};
        ma = '{q: 0, cnt: 0, period: 0, hit: 1'b0, lock: 1'b0, pv: 1'b0};
        mb = ma; mc = ma; md = ma;

        //          rst   ld    en    lv     q      hit   lock  per    pv
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'h00, 5'h01, 1'b0, 1'b0, 5'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h14, 1'b0, 1'b0, 5'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h0A, 1'b0, 1'b0, 5'h00, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h05, 1'b0, 1'b0, 5'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h16, 1'b0, 1'b0, 5'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'h05, 5'h05, 1'b0, 1'b0, 5'h00, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h16, 1'b0, 1'b0, 5'h00, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'h00, 5'h01, 1'b0, 1'b1, 5'h00, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h14, 1'b0, 1'b1, 5'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 5'h0A, 5'h0A, 1'b0, 1'b1, 5'h00, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 5'h00, 5'h0A, 1'b0, 1'b1, 5'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 5'h00, 5'h0A, 1'b0, 1'b1, 5'h00, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 5'h00, 5'h0A, 1'b0, 1'b1, 5'h00, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 5'h03, 5'h03, 1'b0, 1'b1, 5'h00, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 5'h00, 5'h01, 1'b0, 1'b0, 5'h00, 1'b0};

        ra = 1'b1; la = 1'b0; ea = 1'b0; lva = '0;
        rc = 1'b1; lc = 1'b0; ec = 1'b0; lvc = '0;

        // Directed vector table on the default instance; STEPS=2 instance follows the model.
        for (int i = 0; i < 15; i++) begin
            ra = tbl[i].rst; la = tbl[i].ld; ea = tbl[i].en; lva = tbl[i].lv;
            tick();
            if (i == 0) rc = 1'b0;
            chk($sformatf("tbl%0d.q", i), 32'(qa), 32'(tbl[i].q));
            chk($sformatf("tbl%0d.seed_hit", i), 32'(hita), 32'(tbl[i].hit));
            chk($sformatf("tbl%0d.lockup", i), 32'(locka), 32'(tbl[i].lock));
            chk($sformatf("tbl%0d.period", i), 32'(pera), 32'(tbl[i].per));
            chk($sformatf("tbl%0d.period_valid", i), 32'(pva), 32'(tbl[i].pv));
            chk_model("b", mb, 32'(qb), hitb, lockb, 32'(perb), pvb);
        end

        // Full 5-bit cycle from reset: first seed return on en-cycle 31.
        ra = 1'b0; la = 1'b0; ea = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("seq31.a.seed_hit", 32'(hita), 32'(k == 31));
            if (k == 1) chk("seq31.b.q1", 32'(qb), 32'h0A);
            if (k == 2) chk("seq31.b.q2", 32'(qb), 32'h16);
            chk_model("b", mb, 32'(qb), hitb, lockb, 32'(perb), pvb);
        end
        chk("seq31.a.period", 32'(pera), 32'd31);
        chk("seq31.a.period_valid", 32'(pva), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("pre_reset.a.q", 32'(qa), 32'h16);

        // Synchronous reset mid-sequence: nothing moves before the edge.
        ea = 1'b0; ra = 1'b1;
        #3;
        chk("reset_no_async.a.q", 32'(qa), 32'h16);
        chk("reset_no_async.a.period_valid", 32'(pva), 32'd1);
        tick();
        ra = 1'b0;
        chk("reset_mid.a.q", 32'(qa), 32'h01);
        chk("reset_mid.a.period", 32'(pera), 32'd0);
        chk("reset_mid.a.period_valid", 32'(pva), 32'd0);
        chk("reset_mid.a.lockup", 32'(locka), 32'd0);
        chk_group_a();

        // 8-bit Fibonacci instance: period of a maximal sequence is 255.
        rc = 1'b1;
        tick();
        rc = 1'b0; ec = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick();
            chk("fib255.c.seed_hit", 32'(hitc), 32'(k == 255));
            chk_model("d", md, 32'(qd), hitd, lockd, 32'(perd), pvd);
        end
        chk("fib255.c.period", 32'(perc), 32'd255);
        chk("fib255.c.period_valid", 32'(pvc), 32'd1);
        ec = 1'b0;

        // Random en/load/reset traffic on both groups against the reference model.
        for (int n = 0; n < 600; n++) begin
            ra  = ($urandom_range(0, 49) == 0);
            la  = ($urandom_range(0, 9) == 0);
            ea  = ($urandom_range(0, 9) < 7);
            lva = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
            rc  = ($urandom_range(0, 49) == 0);
            lc  = ($urandom_range(0, 9) == 0);
            ec  = ($urandom_range(0, 9) < 7);
            lvc = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tick();
            chk_group_a();
            chk_group_c();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
